// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, memory port and register file.
// Optional memory handshake: define MCTRL_MEM_READY_EN to add mem_ready and wait-state holding.
//
// state      | code | meaning
// -----------+------+-----------------------------------------------
// FETCH      |  0   | read instruction at PC, PC <= PC+4
// DECODE     |  1   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR     |  2   | ALUOut <= rs1+imm (load/store address)
// MEMREAD    |  3   | read data memory at ALUOut
// MEMWB      |  4   | rd <= loaded data
// MEMWRITE   |  5   | write rs2 to data memory at ALUOut
// EXECR      |  6   | ALUOut <= rs1 op rs2
// EXECI      |  7   | ALUOut <= rs1 op imm
// ALUWB      |  8   | rd <= ALUOut
// BRANCH     |  9   | compare rs1/rs2, PC <= ALUOut when taken
// JAL        | 10   | PC <= target, ALUOut <= OldPC+4
// JALRADR    | 11   | ALUOut <= rs1+imm (jalr target)
// LUIWB      | 12   | rd <= ImmExt
// TRAP       | 15   | unknown opcode, parked until reset
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        Zero,
    input  logic        Negative,
`ifdef MCTRL_MEM_READY_EN
    input  logic        mem_ready,
`endif
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [2:0]  ImmSrc,
    output logic        RegWrite,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALRADR  = 4'd11,
        S_LUIWB    = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        w_ready;
    logic        w_taken;
    logic        w_pcwrite;
    logic        w_irwrite;
    logic        w_regwrite;
    logic        w_memwrite;
    logic        w_unused;

`ifdef MCTRL_MEM_READY_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // funct3[2] picks lt/ge vs eq/ne; funct3[0] inverts the sense
    assign w_taken  = funct3[2] ? (Negative ^ funct3[0]) : (Zero ^ funct3[0]);
    assign w_unused = funct3[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= 32'd0;
        end else if (r_state == S_FETCH && w_ready) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BRANCH:              ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALRADR;
                    OP_LUI:            w_next = S_LUIWB;
                    OP_AUIPC:          w_next = S_ALUWB;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = w_ready;
                if (w_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ALUOp     = 2'b01;
                w_pcwrite = w_taken;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JAL;
            end
            S_LUIWB: begin
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                w_next  = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Reset is asynchronous, so enables are gated directly to stop any write the instant it asserts
    assign PCWrite  = w_pcwrite  & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign state    = r_state;
    assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences plus randomized
// instruction streams compared every cycle against a per-instruction state-sequence model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        Zero;
    logic        Negative;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0]  ImmSrc;
    logic [3:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .Zero      (Zero),
        .Negative  (Negative),
`ifdef MCTRL_MEM_READY_EN
        .mem_ready (mem_ready),
`endif
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .illegal   (illegal),
        .state     (state),
        .instret   (instret)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aluop;
        logic [2:0] imm;
        logic       regw;
        logic       ill;
    } outs_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_state;
    int          m_q[$];
    logic [31:0] m_instret;
    int          hs[$], hpc[$], hmw[$], hir[$], hreg[$], hrs[$], hen[$], hill[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy();
`ifdef MCTRL_MEM_READY_EN
        return mem_ready;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'h03, 7'h13, 7'h67: return 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h6F:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            default:             return 3'd0;
        endcase
    endfunction

    // States visited after FETCH for one instruction, by opcode
    task automatic load_seq(input logic [6:0] o);
        m_q.delete();
        case (o)
            7'h03:   m_q = '{1, 2, 3, 4};
            7'h23:   m_q = '{1, 2, 5};
            7'h33:   m_q = '{1, 6, 8};
            7'h13:   m_q = '{1, 7, 8};
            7'h63:   m_q = '{1, 9};
            7'h6F:   m_q = '{1, 10, 8};
            7'h67:   m_q = '{1, 11, 10, 8};
            7'h37:   m_q = '{1, 12};
            7'h17:   m_q = '{1, 8};
            default: m_q = '{1, 15};
        endcase
    endtask

    function automatic outs_t exp_outs(input int s);
        outs_t o;
        logic  cond;
        o     = '0;
        o.imm = imm_of(op);
        case (s)
            0:  begin o.b = 2'd2; o.rs = 2'd2; o.irw = rdy(); o.pcw = rdy(); end
            1:  begin o.a = 2'd1; o.b = 2'd1; end
            2:  begin o.a = 2'd2; o.b = 2'd1; end
            3:  begin o.adr = 1'b1; end
            4:  begin o.rs = 2'd1; o.regw = 1'b1; end
            5:  begin o.adr = 1'b1; o.memw = rdy(); end
            6:  begin o.a = 2'd2; o.aluop = 2'd2; end
            7:  begin o.a = 2'd2; o.b = 2'd1; o.aluop = 2'd2; end
            8:  begin o.regw = 1'b1; end
            9:  begin
                    o.a = 2'd2; o.aluop = 2'd1;
                    cond  = funct3[2] ? Negative : Zero;   // lt/ge use the compare flag, eq/ne use Zero
                    o.pcw = funct3[0] ? !cond : cond;
                end
            10: begin o.a = 2'd1; o.b = 2'd2; o.pcw = 1'b1; end
            11: begin o.a = 2'd2; o.b = 2'd1; end
            12: begin o.rs = 2'd3; o.regw = 1'b1; end
            15: begin o.ill = 1'b1; end
            default: ;
        endcase
        if (reset) begin
            o.pcw = 1'b0; o.irw = 1'b0; o.regw = 1'b0; o.memw = 1'b0;
        end
        return o;
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin
            m_state   = 0;
            m_instret = 32'd0;
            m_q.delete();
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge
    task automatic cycle();
        outs_t       e, d;
        int          nxt;
        logic [31:0] ni;
        @(negedge clk);
        e = exp_outs(m_state);
        d = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal};
        chk("state", {28'd0, state}, m_state);
        chk("outputs", {15'd0, d}, {15'd0, e});
        chk("instret", instret, m_instret);
        hs.push_back(state);   hpc.push_back(PCWrite); hmw.push_back(MemWrite);
        hir.push_back(IRWrite); hreg.push_back(RegWrite); hrs.push_back(ResultSrc);
        hill.push_back(illegal);
        hen.push_back(PCWrite | IRWrite | RegWrite | MemWrite);
        ni = m_instret;
        if (reset) begin
            nxt = 0; ni = 32'd0; m_q.delete();
        end else if (m_state == 0) begin
            if (rdy()) begin
                load_seq(op);
                nxt = m_q.pop_front();
                ni  = m_instret + 32'd1;
            end else begin
                nxt = 0;
            end
        end else if (m_state == 15) begin
            nxt = 15;
        end else if ((m_state == 3 || m_state == 5) && !rdy()) begin
            nxt = m_state;
        end else if (m_q.size() == 0) begin
            nxt = 0;
        end else begin
            nxt = m_q.pop_front();
        end
        @(posedge clk);
        #1;
        m_state   = nxt;
        m_instret = ni;
    endtask

    task automatic clr_hist();
        hs.delete(); hpc.delete(); hmw.delete(); hir.delete();
        hreg.delete(); hrs.delete(); hen.delete(); hill.delete();
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input int n);
        op = o; funct3 = f3;
        clr_hist();
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] pack_nib(input int q[$]);
        logic [31:0] v = 32'd0;
        foreach (q[i]) v = (v << 4) | q[i];
        return v;
    endfunction

    function automatic logic [31:0] pack_bit(input int q[$]);
        logic [31:0] v = 32'd0;
        foreach (q[i]) v = (v << 1) | q[i];
        return v;
    endfunction

    logic [6:0] opl[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        int trap_cycles;
        int bad;
        op = 7'h33; funct3 = 3'd0; Zero = 1'b0; Negative = 1'b0; mem_ready = 1'b1;
        set_reset(1'b1);
        repeat (2) cycle();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_enables", {PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        chk("rst_fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 32'b0_00_10_10);
        set_reset(1'b0);

        run_instr(7'h33, 3'd0, 4);
        chk("add_states", pack_nib(hs), 32'h0168);
        chk("add_regwrite", pack_bit(hreg), 32'b0001);
        chk("add_instret_decode", {31'd0, hs[1] == 1} & 32'd1, 32'd1);
        chk("add_back_to_fetch", {28'd0, state}, 32'd0);
        chk("instret_after_add", instret, 32'd1);

        run_instr(7'h03, 3'd2, 5);
        chk("lw_states", pack_nib(hs), 32'h01234);
        chk("lw_memwrite", pack_bit(hmw), 32'd0);
        chk("lw_resultsrc_wb", hrs[4], 32'd1);
        run_instr(7'h23, 3'd2, 4);
        chk("sw_states", pack_nib(hs), 32'h0125);
        chk("sw_memwrite", pack_bit(hmw), 32'b0001);

        Zero = 1'b1; Negative = 1'b0;
        run_instr(7'h63, 3'b000, 3);
        chk("beq_states", pack_nib(hs), 32'h019);
        chk("beq_taken", pack_bit(hpc), 32'b101);
        run_instr(7'h63, 3'b001, 3);
        chk("bne_not_taken", pack_bit(hpc), 32'b100);
        Zero = 1'b0; Negative = 1'b1;
        run_instr(7'h63, 3'b100, 3);
        chk("blt_taken", pack_bit(hpc), 32'b101);
        Negative = 1'b0;

        run_instr(7'h67, 3'd0, 5);
        chk("jalr_states", pack_nib(hs), 32'h01BA8);
        chk("jalr_pcwrite", pack_bit(hpc), 32'b10010);
        chk("jalr_immsrc", {29'd0, ImmSrc}, 32'd0);
        run_instr(7'h37, 3'd0, 3);
        chk("lui_states", pack_nib(hs), 32'h01C);
        chk("lui_resultsrc", hrs[2], 32'd3);
        run_instr(7'h17, 3'd0, 3);
        chk("auipc_states", pack_nib(hs), 32'h018);
        chk("instret_after_directed", instret, 32'd9);

        run_instr(7'h00, 3'd0, 3);
        chk("trap_entry", pack_nib(hs), 32'h01F);
        clr_hist();
        repeat (20) cycle();
        bad = 0;
        foreach (hs[i]) if (hs[i] != 15 || hill[i] != 1 || hen[i] != 0) bad++;
        chk("trap_hold_20", bad, 32'd0);
        set_reset(1'b1);
        #1;
        chk("trap_reset_state", {28'd0, state}, 32'd0);
        chk("trap_reset_illegal", {31'd0, illegal}, 32'd0);
        cycle();
        set_reset(1'b0);

`ifdef MCTRL_MEM_READY_EN
        mem_ready = 1'b0;
        run_instr(7'h33, 3'd0, 3);
        chk("hold_fetch_states", pack_nib(hs), 32'h000);
        chk("hold_fetch_irwrite", pack_bit(hir), 32'd0);
        chk("hold_fetch_instret", instret, 32'd0);
        mem_ready = 1'b1;
        clr_hist();
        cycle();
        chk("release_irwrite", hir[0], 32'd1);
        chk("release_decode", {28'd0, state}, 32'd1);
        chk("release_instret", instret, 32'd1);
        repeat (2) cycle();
`endif

        trap_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            if (reset) begin
                set_reset(1'b0);
            end else if (trap_cycles >= 20 || $urandom_range(0, 149) == 0) begin
                set_reset(1'b1);
            end
            if (m_state == 0) begin
                if ($urandom_range(0, 19) == 0) op = 7'($urandom);
                else                           op = opl[$urandom_range(0, 8)];
                funct3 = 3'($urandom);
            end
            Zero     = 1'($urandom);
            Negative = 1'($urandom);
`ifdef MCTRL_MEM_READY_EN
            mem_ready = ($urandom_range(0, 3) != 0);
`endif
            cycle();
            trap_cycles = (m_state == 15) ? trap_cycles + 1 : 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one shared instruction/data memory port and the register file over 3–5 cycles per instruction. It keeps the single-cycle decoder's ALUOp, ImmSrc and ResultSrc encodings so the existing ALU decoder and immediate extender are reused unchanged. It also keeps a retired-fetch counter and parks in a trap state on unknown opcodes.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; state register to FETCH, instret to 0
- op  in  7  opcode from instruction register (stable after FETCH)
- funct3  in  3  from instruction register
- Zero  in  1  ALU result == 0
- Negative  in  1  ALU compare flag (signed/unsigned selected by ALU decoder)
- mem_ready  in  1  memory handshake (present only with MCTRL_MEM_READY_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4
- ALUOp  out  2  00=add, 01=branch compare, 10=funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable
- illegal  out  1  high while in TRAP
- state  out  4  current state, debug
- instret  out  32  completed-fetch count

## Operation
- ImmSrc is combinational from op in every state: load/I/jalr→000, store→001, branch→010, jal→011, lui/auipc→100, other→000.
- Every output not listed for a state is 0.
- States, with their outputs and next state:
  - FETCH(0): AdrSrc=0, IRWrite, A=00, B=10, ALUOp=00, ResultSrc=10, PCWrite → DECODE.
  - DECODE(1): A=01, B=01, ALUOp=00. Next state by op:
    - load/store → MEMADR
    - R → EXECR
    - I → EXECI
    - branch → BRANCH
    - jal → JAL
    - jalr → JALRADR
    - lui → LUIWB
    - auipc → ALUWB (ALUOut already holds OldPC+imm)
    - other → TRAP
  - MEMADR(2): A=10, B=01, ALUOp=00 → MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00 → MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite → FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite → FETCH.
  - EXECR(6): A=10, B=00, ALUOp=10 → ALUWB.
  - EXECI(7): A=10, B=01, ALUOp=10 → ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite → FETCH.
  - BRANCH(9): A=10, B=00, ALUOp=01, ResultSrc=00. PCWrite = taken, where taken = funct3[2] ? (Negative^funct3[0]) : (Zero^funct3[0]) → FETCH.
  - JAL(10): A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite → ALUWB (writes OldPC+4).
  - JALRADR(11): A=10, B=01, ALUOp=00 → JAL.
  - LUIWB(12): ResultSrc=11, RegWrite → FETCH.
  - TRAP(15): illegal=1, all enables 0, holds until reset.
  - Codes 13 and 14 are unused and go to TRAP.
- instret increments by 1 in each cycle where FETCH advances to DECODE; wraps 0xFFFFFFFF→0.

## Timing
- State register and instret update on rising clk; all other outputs are combinational from state, op, funct3 and flags.
- While reset is high: state=FETCH, instret=0, and PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The other outputs show FETCH values.
- Reset asserted mid-instruction aborts it immediately; no partial write occurs after assertion.
- Cycles per instruction (FETCH through last state, without wait):
  - branch, lui, auipc: 3
  - R, I, store, jal: 4
  - load, jalr: 5
- The next instruction's FETCH follows the last state with no gap.

## Configuration
- MCTRL_MEM_READY_EN defined:
  - mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In held cycles, FETCH suppresses IRWrite and PCWrite, MEMWRITE suppresses MemWrite, and instret does not count.
  - AdrSrc and the ALU selects stay stable while held.
  - Each of those states advances in the first cycle with mem_ready=1.
- Not defined: port absent, every state takes exactly one cycle.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3): states 0,1,6,8,0; RegWrite only in cycle 4; instret=1 after first FETCH.
- lw (op 0000011) then sw (0100011): states 0,1,2,3,4 then 0,1,2,5; MemWrite=1 only in state 5; ResultSrc=01 in state 4.
- beq with Zero=1 → PCWrite=1 in BRANCH. bne (funct3=001) with Zero=1 → PCWrite=0. blt (100) with Negative=1 → PCWrite=1.
- jalr: states 0,1,11,10,8; PCWrite in 0 and 10; ImmSrc=000. lui: 0,1,12 with ResultSrc=11. auipc: 0,1,8.
- op=0000000: DECODE→TRAP, illegal=1, all enables 0 for 20 cycles; reset mid-TRAP → FETCH, illegal=0.
- With MCTRL_MEM_READY_EN: mem_ready=0 for 3 cycles during FETCH → state stays 0, IRWrite=0, instret unchanged; mem_ready=1 → IRWrite=1, DECODE next.
